// File: rtl/shared_reg_pkg.sv
// Shared types and helpers for the shared-register arbiter slice.
package shared_reg_pkg;

    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        DONE  = 2'd2
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [MAX_IDX_W-1:0] idx);
        onehot = {{(MAX_REQ-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin finder: first set req bit at or above ptr, wrapping at N_REQ.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest candidate back to ptr so the nearest set bit is the last one kept.
    always_comb begin
        winner   = {IDX_W{1'b0}};
        cand     = 0;
        cand_idx = {IDX_W{1'b0}};
        any_req  = |req;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand     = (int'(ptr) + k) % N_REQ;
            cand_idx = IDX_W'(cand);
            winner   = req[cand_idx] ? cand_idx : winner;
        end
    end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter and three-state write sequencer for one shared storage register.
module shared_reg_arbiter
    import shared_reg_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   wdata,
    input  logic                      clr,
    output logic [N_REQ-1:0]          grant,
    output logic [DATA_W-1:0]         q,
    output logic [$clog2(N_REQ)-1:0]  owner,
    output logic                      done,
    output logic                      busy
);

    localparam int IDX_W = $clog2(N_REQ);

    state_e             state_q, state_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic               done_q, done_d;
    logic               busy_q, busy_d;
    logic [DATA_W-1:0]  q_q, q_d;
    logic               write_en;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic [MAX_REQ-1:0] grant_full;
    logic [DATA_W-1:0]  slices [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign slices[i] = wdata[i*DATA_W +: DATA_W];
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (winner),
        .any_req (any_req)
    );

    // Next-state logic for the sequencer; owner_q doubles as the in-flight winner during GRANT.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        done_d     = 1'b0;
        write_en   = 1'b0;
        grant_full = onehot(MAX_IDX_W'(winner));
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = grant_full[N_REQ-1:0];
                    owner_d = winner;
                    state_d = GRANT;
                end else begin
                    state_d = IDLE;
                end
            end
            GRANT: begin
                write_en = 1'b1;
                ptr_d    = (owner_q == IDX_W'(N_REQ - 1)) ? {IDX_W{1'b0}} : owner_q + IDX_W'(1'b1);
                grant_d  = {N_REQ{1'b0}};
                done_d   = 1'b1;
                state_d  = DONE;
            end
            DONE: begin
                grant_d = {N_REQ{1'b0}};
                state_d = IDLE;
            end
            default: begin
                grant_d = {N_REQ{1'b0}};
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // Storage bank input: clear wins over a write closing on the same edge.
    always_comb begin
        if (clr) begin
            q_d = {DATA_W{1'b0}};
        end else if (write_en) begin
            q_d = slices[owner_q];
        end else begin
            q_d = q_q;
        end
    end

    // Sequencer and arbitration state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= {N_REQ{1'b0}};
            owner_q <= {IDX_W{1'b0}};
            ptr_q   <= {IDX_W{1'b0}};
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
        end
    end

    // Shared storage register.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q <= {DATA_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign grant = grant_q;
    assign q     = q_q;
    assign owner = owner_q;
    assign done  = done_q;
    assign busy  = busy_q;

endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

- Round-robin arbiter and write sequencer for one shared DATA_W-bit storage register built from synchronous-reset D flip-flops.
- Up to N_REQ requesters compete for write access; each write is granted, captured and acknowledged in a fixed three-state sequence.
- The current register contents and the identity of the last writer are visible to all.
- Sits between requester logic and the shared register; it is the only agent that drives the register's D/enable.

## Interface

- N_REQ, default 4: number of requesters, 2..8.
- DATA_W, default 8: width of the shared register.
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- req  in  N_REQ  request per requester; held high until done seen with owner equal to own index.
- wdata  in  N_REQ*DATA_W  write data; requester i drives slice [i*DATA_W +: DATA_W], stable while req[i] high.
- clr  in  1  synchronous clear of the shared register.
- grant  out  N_REQ  one-hot grant, registered.
- q  out  DATA_W  shared register contents.
- owner  out  $clog2(N_REQ)  index of last granted requester.
- done  out  1  one-cycle write-complete pulse.
- busy  out  1  high whenever state is not IDLE.

## Operation

- Reset values: grant=0, q=0, owner=0, done=0, busy=0, state=IDLE, rr pointer=0 (requester 0 highest priority).
- IDLE
  - If any req bit is set, pick the winner w: the first set bit scanning from the pointer upward, wrapping modulo N_REQ.
  - Register grant=onehot(w) and owner=w, then go to GRANT.
  - If no req bit is set, stay in IDLE.
- GRANT (exactly 1 cycle)
  - grant[w]=1.
  - At the closing edge: q <= wdata slice w, pointer <= (w+1) mod N_REQ, grant <= 0, done <= 1, state <= DONE.
  - Data is captured even if req[w] dropped during GRANT.
- DONE (exactly 1 cycle)
  - done=1, grant=0.
  - Next state is IDLE.
  - req is ignored for arbitration in this cycle, so a requester has this cycle to drop req.
- Fairness
  - A requester still asserting req after its done is re-served only after every other asserting requester has been served.
  - Worst-case wait is N_REQ-1 full transactions.
- clr
  - When clr=1 at an edge, q <= 0.
  - clr has priority over a write closing on the same edge: the write is discarded, while pointer, owner and done update normally.
  - clr never changes state, grant or pointer.
- Reset mid-transaction (in GRANT or DONE) aborts it: no write, no done; all outputs return to their reset values on that edge.
- req bits for indices ≥ N_REQ do not exist; the pointer wraps at N_REQ-1 → 0.

## Timing

- Edge k samples req (IDLE). grant is high in cycle k..k+1, q updates and done rises at edge k+1, done falls at edge k+2, busy is low after edge k+2.
- Request-to-q latency: 2 edges.
- Throughput: one write per 3 cycles with continuous requests.
- grant, done, busy, owner and q are all registered outputs; no combinational path from req to any output.
- owner is valid from the edge grant rises and holds until the next grant.

## Structure

- Shared package `shared_reg_pkg`:
  - state enum {IDLE, GRANT, DONE}
  - MAX_REQ=8
  - function onehot(idx)
- Sub-module `rr_pick`: combinational round-robin first-set-bit finder.
  - Inputs: req, pointer.
  - Outputs: winner index, any_req.
- The storage register is a DATA_W-wide bank with synchronous active-high reset and write enable, inferred inside the top.

## Test plan

- **Reset:** rst=1 for 2 cycles with req=4'b1111 → grant=0, q=8'h00, done=0, busy=0; first winner after release is requester 0.
- **Single write:** req=4'b0100, wdata[2]=8'hA5 → grant=4'b0100 for one cycle, q=8'hA5 and done=1 one edge later, owner=2.
- **Round-robin:** req=4'b1111 held, slices 8'h10/8'h20/8'h30/8'h40 → grant order 0,1,2,3,0; q sequence 10,20,30,40,10; done every 3rd cycle.
- **Wrap and skip:** pointer=3 (after serving 2), req=4'b0011 → requester 0 granted before 1; then 1; pointer ends at 2.
- **clr collision:** clr=1 on the edge closing a write of 8'hFF → q=8'h00, done=1, owner updated; clr in IDLE with q=8'h5A → q=8'h00, state unchanged.
- **Reset mid-operation:** rst asserted during GRANT of a write of 8'h77 → q stays 8'h00, no done pulse, pointer=0, busy=0 next cycle.
